// File: rtl/grf_wb_arbiter_if.sv
// rtl/grf_wb_arbiter_if.sv - pipeline, multi-cycle and GRF write-port signal bundle
// The arbiter uses the slave modport; the requester/GRF side uses master.
interface grf_wb_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_a3;
  logic [31:0] pipe_wd;
  logic [31:0] pipe_pc;

  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_a3;
  logic [31:0] mdu_wd;
  logic [31:0] mdu_pc;

  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  logic        stall_pipe;
  logic [31:0] pend_mask;

  modport master (
    output pipe_we, pipe_a3, pipe_wd, pipe_pc,
    output mdu_valid, mdu_a3, mdu_wd, mdu_pc,
    input  mdu_ready,
    input  grf_we, grf_a3, grf_wd, grf_pc,
    input  stall_pipe, pend_mask
  );

  modport slave (
    input  pipe_we, pipe_a3, pipe_wd, pipe_pc,
    input  mdu_valid, mdu_a3, mdu_wd, mdu_pc,
    output mdu_ready,
    output grf_we, grf_a3, grf_wd, grf_pc,
    output stall_pipe, pend_mask
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - GRF write-port arbiter: pipeline priority, buffered multi-cycle writes
// The FIFO head may lose the port to the pipeline at most MAX_WAIT times before a forced issue.
module grf_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input logic            clk,
  input logic            reset,
  grf_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUEUED = 2'd1,
    ST_FORCE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]      wait_q, wait_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]      mem_a3_q [DEPTH];
  logic [4:0]      mem_a3_d [DEPTH];
  logic [31:0]     mem_wd_q [DEPTH];
  logic [31:0]     mem_wd_d [DEPTH];
  logic [31:0]     mem_pc_q [DEPTH];
  logic [31:0]     mem_pc_d [DEPTH];

  logic        pipe_req;
  logic        ready;
  logic        push;
  logic        pop;
  logic        grant_pipe;
  logic        grant_head;
  logic [3:0]  wait_inc;
  logic [31:0] pend;

  always_comb begin
    pipe_req = bus.pipe_we && (bus.pipe_a3 != 5'd0);
    ready    = !reset && (count_q < CW'(DEPTH));
    push     = bus.mdu_valid && ready && (bus.mdu_a3 != 5'd0);
    wait_inc = wait_q + 4'd1;
  end

  // Grant decode: reset blocks every write; FORCE hands the port to the head unconditionally.
  always_comb begin
    grant_pipe = 1'b0;
    grant_head = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE:   grant_pipe = pipe_req;
        ST_QUEUED: begin
          if (pipe_req) grant_pipe = 1'b1;
          else          grant_head = 1'b1;
        end
        ST_FORCE:  grant_head = 1'b1;
        default:   ;
      endcase
    end
    pop = grant_head;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wait_d   = wait_q;
    valid_d  = valid_q;
    mem_a3_d = mem_a3_q;
    mem_wd_d = mem_wd_q;
    mem_pc_d = mem_pc_q;

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q]  = 1'b1;
      mem_a3_d[wr_ptr_q] = bus.mdu_a3;
      mem_wd_d[wr_ptr_q] = bus.mdu_wd;
      mem_pc_d[wr_ptr_q] = bus.mdu_pc;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        wait_d = 4'd0;
        if (push) state_d = ST_QUEUED;
      end
      ST_QUEUED: begin
        if (pop) begin
          wait_d  = 4'd0;
          state_d = (count_d == '0) ? ST_IDLE : ST_QUEUED;
        end else begin
          wait_d  = wait_inc;
          state_d = (wait_inc == 4'(MAX_WAIT)) ? ST_FORCE : ST_QUEUED;
        end
      end
      ST_FORCE: begin
        wait_d  = 4'd0;
        state_d = (count_d == '0) ? ST_IDLE : ST_QUEUED;
      end
      default: begin
        wait_d  = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wait_q   <= 4'd0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wait_q   <= wait_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset; valid_q qualifies every read.
  always_ff @(posedge clk) begin
    mem_a3_q <= mem_a3_d;
    mem_wd_q <= mem_wd_d;
    mem_pc_q <= mem_pc_d;
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pend[mem_a3_q[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  always_comb begin
    bus.grf_we = 1'b0;
    bus.grf_a3 = 5'd0;
    bus.grf_wd = 32'd0;
    bus.grf_pc = 32'd0;
    if (grant_head) begin
      bus.grf_we = 1'b1;
      bus.grf_a3 = mem_a3_q[rd_ptr_q];
      bus.grf_wd = mem_wd_q[rd_ptr_q];
      bus.grf_pc = mem_pc_q[rd_ptr_q];
    end else if (grant_pipe) begin
      bus.grf_we = 1'b1;
      bus.grf_a3 = bus.pipe_a3;
      bus.grf_wd = bus.pipe_wd;
      bus.grf_pc = bus.pipe_pc;
    end
  end

  assign bus.mdu_ready  = ready;
  assign bus.stall_pipe = !reset && (state_q == ST_FORCE);
  assign bus.pend_mask  = reset ? 32'd0 : pend;
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - directed bench for grf_wb_arbiter with a queue-based reference model
// Model state: a queue of pending writes and the number of cycles the head has been bypassed.
module tb_grf_wb_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic reset;
  grf_wb_arbiter_if bus();

  grf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  int   m_wait;
  bit   model_on;
  int   tests;
  int   fails;

  logic        e_we, e_stall, e_ready, e_pop, e_pipe_won;
  logic [4:0]  e_a3;
  logic [31:0] e_wd, e_pc, e_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit pr;
    e_we = 0; e_a3 = 0; e_wd = 0; e_pc = 0;
    e_stall = 0; e_ready = 0; e_pend = 0; e_pop = 0; e_pipe_won = 0;
    if (!reset) begin
      e_ready = (mq.size() < DEPTH);
      foreach (mq[i]) e_pend[mq[i].a3] = 1'b1;
      pr = bus.pipe_we && (bus.pipe_a3 != 5'd0);
      if (mq.size() > 0 && m_wait >= MAX_WAIT) begin
        e_stall = 1'b1;
        e_pop   = 1'b1;
      end else if (pr) begin
        e_pipe_won = 1'b1;
      end else if (mq.size() > 0) begin
        e_pop = 1'b1;
      end
      if (e_pop) begin
        e_we = 1'b1; e_a3 = mq[0].a3; e_wd = mq[0].wd; e_pc = mq[0].pc;
      end else if (e_pipe_won) begin
        e_we = 1'b1; e_a3 = bus.pipe_a3; e_wd = bus.pipe_wd; e_pc = bus.pipe_pc;
      end
    end
  endtask

  always @(posedge clk) begin
    model_eval();
    if (reset) begin
      mq.delete();
      m_wait   = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (e_pop) begin
        mq.delete(0);
        m_wait = 0;
      end else if (e_pipe_won && mq.size() > 0) begin
        m_wait++;
      end
      if (bus.mdu_valid && e_ready && bus.mdu_a3 != 5'd0)
        mq.push_back('{a3: bus.mdu_a3, wd: bus.mdu_wd, pc: bus.mdu_pc});
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      model_eval();
      check("model grf_we",     bus.grf_we,     e_we);
      check("model grf_a3",     bus.grf_a3,     e_a3);
      check("model grf_wd",     bus.grf_wd,     e_wd);
      check("model grf_pc",     bus.grf_pc,     e_pc);
      check("model stall_pipe", bus.stall_pipe, e_stall);
      check("model mdu_ready",  bus.mdu_ready,  e_ready);
      check("model pend_mask",  bus.pend_mask,  e_pend);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_pipe(input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    bus.pipe_we = we; bus.pipe_a3 = a3; bus.pipe_wd = wd; bus.pipe_pc = pc;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    bus.mdu_valid = v; bus.mdu_a3 = a3; bus.mdu_wd = wd; bus.mdu_pc = pc;
  endtask

  initial begin
    tests = 0; fails = 0; model_on = 1'b0; m_wait = 0;
    reset = 1'b1;
    drive_pipe(1, 5'd5, 32'h1111, 32'h100);
    drive_mdu(1, 5'd7, 32'h7777, 32'h200);
    step(); step();
    mid();
    check("reset grf_we",    bus.grf_we,    1'b0);
    check("reset mdu_ready", bus.mdu_ready, 1'b0);
    check("reset pend_mask", bus.pend_mask, 32'h0);
    check("reset stall",     bus.stall_pipe, 1'b0);

    step(); reset = 1'b0;
    drive_pipe(0, 5'd0, 32'h0, 32'h0);
    drive_mdu(0, 5'd0, 32'h0, 32'h0);
    mid();
    check("idle mdu_ready", bus.mdu_ready, 1'b1);
    check("idle grf_we",    bus.grf_we,    1'b0);

    step(); drive_pipe(1, 5'd5, 32'h1234, 32'h3000);
    mid();
    check("pipe grf_we", bus.grf_we, 1'b1);
    check("pipe grf_a3", bus.grf_a3, 32'd5);
    check("pipe grf_wd", bus.grf_wd, 32'h1234);
    check("pipe grf_pc", bus.grf_pc, 32'h3000);

    step(); drive_pipe(1, 5'd0, 32'h5555, 32'h3004);
    mid();
    check("pipe r0 grf_we", bus.grf_we, 1'b0);
    check("pipe r0 grf_a3", bus.grf_a3, 32'd0);

    step(); drive_pipe(0, 5'd0, 32'h0, 32'h0);
    drive_mdu(1, 5'd8, 32'hDEADBEEF, 32'h4000);
    mid();
    check("mdu enq grf_we", bus.grf_we, 1'b0);
    step(); drive_mdu(0, 5'd0, 32'h0, 32'h0);
    mid();
    check("mdu issue grf_we",   bus.grf_we,    1'b1);
    check("mdu issue grf_a3",   bus.grf_a3,    32'd8);
    check("mdu issue grf_wd",   bus.grf_wd,    32'hDEADBEEF);
    check("mdu issue grf_pc",   bus.grf_pc,    32'h4000);
    check("mdu issue pend",     bus.pend_mask, 32'h100);
    step(); mid();
    check("mdu done pend",   bus.pend_mask, 32'h0);
    check("mdu done grf_we", bus.grf_we,    1'b0);

    step(); drive_pipe(1, 5'd1, 32'hAAAA, 32'h5000);
    drive_mdu(1, 5'd9, 32'h9, 32'h900);
    step(); drive_mdu(1, 5'd10, 32'hA, 32'hA00);
    mid();
    check("full1 grf_a3", bus.grf_a3,    32'd1);
    check("full1 pend",   bus.pend_mask, 32'h200);
    check("full1 ready",  bus.mdu_ready, 1'b1);
    step(); drive_mdu(1, 5'd11, 32'hB, 32'hB00);
    mid();
    check("full2 ready",  bus.mdu_ready, 1'b0);
    check("full2 pend",   bus.pend_mask, 32'h600);
    check("full2 grf_a3", bus.grf_a3,    32'd1);
    check("full2 stall",  bus.stall_pipe, 1'b0);
    step(); mid();
    check("full3 ready", bus.mdu_ready, 1'b0);
    step(); step(); mid();
    check("force stall",  bus.stall_pipe, 1'b1);
    check("force grf_a3", bus.grf_a3,     32'd9);
    check("force grf_wd", bus.grf_wd,     32'h9);
    check("force ready",  bus.mdu_ready,  1'b0);
    step(); mid();
    check("after force stall",  bus.stall_pipe, 1'b0);
    check("after force grf_a3", bus.grf_a3,     32'd1);
    check("after force grf_wd", bus.grf_wd,     32'hAAAA);
    check("after force ready",  bus.mdu_ready,  1'b1);
    check("after force pend",   bus.pend_mask,  32'h400);
    step(); drive_mdu(0, 5'd0, 32'h0, 32'h0); drive_pipe(0, 5'd0, 32'h0, 32'h0);
    mid();
    check("drain1 grf_a3", bus.grf_a3,    32'd10);
    check("drain1 pend",   bus.pend_mask, 32'hC00);
    step(); mid();
    check("drain2 grf_a3", bus.grf_a3,    32'd11);
    check("drain2 grf_wd", bus.grf_wd,    32'hB);
    check("drain2 pend",   bus.pend_mask, 32'h800);
    step(); mid();
    check("drain3 grf_we", bus.grf_we,    1'b0);
    check("drain3 pend",   bus.pend_mask, 32'h0);

    drive_mdu(1, 5'd0, 32'h5, 32'hC00);
    mid();
    check("r0 enq ready", bus.mdu_ready, 1'b1);
    step(); drive_mdu(0, 5'd0, 32'h0, 32'h0);
    mid();
    check("r0 enq grf_we", bus.grf_we,    1'b0);
    check("r0 enq pend",   bus.pend_mask, 32'h0);

    step(); drive_pipe(1, 5'd2, 32'h22, 32'hD00);
    drive_mdu(1, 5'd3, 32'h33, 32'hD04);
    step(); drive_mdu(0, 5'd0, 32'h0, 32'h0);
    mid();
    check("rstq pend",   bus.pend_mask, 32'h8);
    check("rstq grf_a3", bus.grf_a3,    32'd2);
    step(); reset = 1'b1; drive_pipe(0, 5'd0, 32'h0, 32'h0);
    mid();
    check("rstq in-reset grf_we", bus.grf_we,     1'b0);
    check("rstq in-reset stall",  bus.stall_pipe, 1'b0);
    step(); mid();
    check("rstq pend cleared", bus.pend_mask, 32'h0);
    step(); reset = 1'b0;
    mid();
    check("rstq no write r3", bus.grf_we,    1'b0);
    check("rstq ready",       bus.mdu_ready, 1'b1);

    for (int i = 0; i < 48; i++) begin
      step();
      if (!bus.stall_pipe)
        drive_pipe(1'((i % 3) != 0), 5'((i * 7) % 32), 32'(i * 32'h11), 32'h6000 + 32'(i * 4));
      drive_mdu(1'((i % 2) == 0 || (i % 5) == 0), 5'((i * 3) % 32), 32'hF000 + 32'(i), 32'h7000 + 32'(i * 4));
    end
    step();
    drive_pipe(0, 5'd0, 32'h0, 32'h0);
    drive_mdu(0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) step();
    mid();
    check("final grf_we", bus.grf_we,    1'b0);
    check("final pend",   bus.pend_mask, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-port arbiter and scheduler for the 32×32 general register file (GRF). It shares the GRF's single write port between two requesters: the main pipeline writeback, which has priority and no handshake, and a multi-cycle unit such as the multiply/divide unit, which uses a valid/ready handshake. Accepted multi-cycle requests are buffered in a small FIFO and issued to the GRF whenever the pipeline leaves the port idle. A starvation counter forces a pipeline stall if the FIFO head waits too long, and a pending-write mask lets the hazard logic interlock on registers with queued writes.

## Interface
- DEPTH, 2: FIFO entries for multi-cycle requests (power of two, 2..8).
- MAX_WAIT, 4: cycles the FIFO head may wait before a forced stall (1..15).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- pipe_we  in  1  pipeline writeback request.
- pipe_a3  in  5  pipeline destination register.
- pipe_wd  in  32  pipeline write data.
- pipe_pc  in  32  PC of the pipeline instruction (trace).
- mdu_valid  in  1  multi-cycle request valid.
- mdu_ready  out  1  arbiter can accept a multi-cycle request.
- mdu_a3  in  5  multi-cycle destination register.
- mdu_wd  in  32  multi-cycle write data.
- mdu_pc  in  32  PC of the originating instruction.
- grf_we  out  1  GRF RegWrite.
- grf_a3  out  5  GRF A3.
- grf_wd  out  32  GRF WriteData.
- grf_pc  out  32  GRF PC (trace).
- stall_pipe  out  1  pipeline must freeze and hold pipe_* this cycle.
- pend_mask  out  32  bit r set when a write to $r is queued.

## Operation
- Effective requests:
  - pipe_req = pipe_we && pipe_a3 != 0.
  - head_req = FIFO not empty.
- Enqueue:
  - A handshake occurs when mdu_valid && mdu_ready at the posedge.
  - An entry is stored only if mdu_a3 != 0. Requests to $0 are acknowledged and discarded.
- mdu_ready = !reset && (count < DEPTH). It is computed from the registered count only, so a pop in the same cycle does not free a slot for a push when the FIFO is full.
- The state machine has three states:
  - IDLE: FIFO empty.
    - Port goes to the pipeline if pipe_req, otherwise grf_we=0.
    - Moves to QUEUED on enqueue.
  - QUEUED: FIFO not empty, wait_cnt < MAX_WAIT.
    - If pipe_req, the pipeline wins and wait_cnt increments. Otherwise the head is issued and popped, and wait_cnt clears.
    - Goes to FORCE when wait_cnt reaches MAX_WAIT.
    - Goes to IDLE when the last entry pops and no push occurs.
  - FORCE: stall_pipe=1.
    - Head is issued regardless of pipe_we; the pipeline write is not performed and the pipeline re-presents it next cycle.
    - Pop, clear wait_cnt, then go to QUEUED or IDLE by the resulting count.
    - Exactly one cycle per occurrence.
- Output mux (combinational):
  - Pipeline granted: grf_* = pipe_*, grf_we=1.
  - Head granted: grf_* = head fields, grf_we=1.
  - Otherwise grf_we=0, and grf_a3, grf_wd, grf_pc are 0.
- pend_mask is the OR of the one-hot decode of the a3 field over all valid FIFO entries, registered state only. Bit 0 is always 0.
- Ordering:
  - Multi-cycle writes issue in FIFO order.
  - If the pipeline and the head target the same register in one cycle, the pipeline writes now and the head writes later, so the head value is final. The hazard unit must use pend_mask to prevent this.
- Push and pop in the same cycle: count unchanged, pointers wrap modulo DEPTH.

## Timing
- Reset values (cycle after reset asserted):
  - count=0, pointers=0, wait_cnt=0, state IDLE.
  - pend_mask=0, stall_pipe=0, grf_we=0, mdu_ready=0 while reset is high.
- Reset mid-operation discards all queued entries. No GRF write occurs in any cycle where reset is high.
- Latency:
  - Pipeline write: 0 cycles, combinational passthrough to the GRF, committed at the same posedge.
  - Multi-cycle write with a free port: enqueued at edge N, issued during cycle N+1 and committed at edge N+1.
- Worst-case head wait: MAX_WAIT cycles, then a forced issue on the next cycle.
- stall_pipe is a registered-state decode (state==FORCE), glitch-free within the cycle.
- A pop updates pend_mask at the following edge.

## Test plan
- Reset then idle: reset=1 for 2 cycles → grf_we=0, mdu_ready=0, pend_mask=0; after release, mdu_ready=1.
- Pipeline only: pipe_we=1, a3=5, wd=0x1234, pc=0x3000 → same cycle grf_we=1, grf_a3=5, grf_wd=0x1234. With pipe_a3=0 → grf_we=0.
- MDU on a free port: enqueue a3=8, wd=0xDEADBEEF → next cycle grf_we=1, grf_a3=8, pend_mask=0x100 during that cycle, then 0.
- Full FIFO (DEPTH=2): pipe_we=1 continuously, enqueue a3=9 then a3=10 → mdu_ready=0, pend_mask=0x600; a third mdu_valid is held off.
- Starvation (MAX_WAIT=4): pipe_we=1 every cycle with one entry queued → stall_pipe=1 on the 5th cycle, head issued, pipeline write suppressed; the following cycle the pipeline write completes.
- $0 and reset mid-queue: enqueue a3=0 → acknowledged, count stays 0. Enqueue a3=3, then assert reset → no write to $3, pend_mask=0.
